// File: rtl/regfile_pkg.sv
// regfile_pkg: shared widths, requester indices and buffer state
// for the register-file write arbiter slice.
package regfile_pkg;

  localparam int ADDR_W   = 5;
  localparam int DATA_W   = 32;
  localparam int NUM_REGS = 32;

  localparam logic [4:0] ZERO_REG = 5'd0;

  localparam int REQ_ALU = 0;
  localparam int REQ_MEM = 1;

  typedef enum logic {
    BUF_EMPTY,
    BUF_FULL
  } buf_state_e;

endpackage

// File: rtl/regfile_write_arbiter_wb_hold_buffer.sv
// wb_hold_buffer: one-entry writeback holding buffer; accepts while empty
// or while being drained, and swallows writes aimed at the zero register.
module wb_hold_buffer
  import regfile_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [ADDR_W-1:0] in_reg,
  input  logic [DATA_W-1:0] in_data,
  input  logic              grant,
  output logic              ready,
  output logic              load,
  output logic              full,
  output logic [ADDR_W-1:0] buf_reg,
  output logic [DATA_W-1:0] buf_data
);

  buf_state_e state;

  assign full  = (state == BUF_FULL);
  assign ready = !full || grant;
  assign load  = in_valid && ready
              && (in_reg != ADDR_W'(ZERO_REG));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BUF_EMPTY;
      buf_reg  <= '0;
      buf_data <= '0;
    end else begin
      unique case (1'b1)
        load: begin
          state    <= BUF_FULL;
          buf_reg  <= in_reg;
          buf_data <= in_data;
        end
        grant && !load: state <= BUF_EMPTY;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: two writeback requesters share one regfile port.
// Define REGFILE_WRITE_BYPASS_EN to add fwd_valid_x/fwd_data_x forwarding.
module regfile_write_arbiter
  import regfile_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 5,
  parameter int NUM_REGS   = 32,
  parameter int FIXED_PRIO = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_0,
  input  logic [ADDR_W-1:0] req_reg_0,
  input  logic [DATA_W-1:0] req_data_0,
  output logic              req_ready_0,
  input  logic              req_valid_1,
  input  logic [ADDR_W-1:0] req_reg_1,
  input  logic [DATA_W-1:0] req_data_1,
  output logic              req_ready_1,
  input  logic [ADDR_W-1:0] read_reg_1,
  input  logic [ADDR_W-1:0] read_reg_2,
`ifdef REGFILE_WRITE_BYPASS_EN
  output logic              fwd_valid_1,
  output logic [DATA_W-1:0] fwd_data_1,
  output logic              fwd_valid_2,
  output logic [DATA_W-1:0] fwd_data_2,
`endif
  output logic              read_stall,
  output logic              signal_reg_write,
  output logic [ADDR_W-1:0] write_reg,
  output logic [DATA_W-1:0] write_data
);

  logic [1:0]        full, load, gnt;
  logic [ADDR_W-1:0] breg  [2];
  logic [DATA_W-1:0] bdata [2];
  logic              rr_q, age_q;
  logic              pick0, same_dst;
  logic [NUM_REGS-1:0] pending;
  logic [1:0]        hit;

  wb_hold_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf_alu (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (req_valid_0),
    .in_reg   (req_reg_0),
    .in_data  (req_data_0),
    .grant    (gnt[REQ_ALU]),
    .ready    (req_ready_0),
    .load     (load[REQ_ALU]),
    .full     (full[REQ_ALU]),
    .buf_reg  (breg[REQ_ALU]),
    .buf_data (bdata[REQ_ALU])
  );

  wb_hold_buffer #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_buf_mem (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (req_valid_1),
    .in_reg   (req_reg_1),
    .in_data  (req_data_1),
    .grant    (gnt[REQ_MEM]),
    .ready    (req_ready_1),
    .load     (load[REQ_MEM]),
    .full     (full[REQ_MEM]),
    .buf_reg  (breg[REQ_MEM]),
    .buf_data (bdata[REQ_MEM])
  );

  assign same_dst = (breg[REQ_ALU] == breg[REQ_MEM]);
  assign pick0    = (FIXED_PRIO != 0) || !rr_q;

  // age_q = 1 means the MEM buffer holds the older entry
  always_comb begin
    gnt = 2'b00;
    unique case (1'b1)
      full == 2'b01: gnt = 2'b01;
      full == 2'b10: gnt = 2'b10;
      full == 2'b11 && same_dst:
        gnt = age_q ? 2'b10 : 2'b01;
      full == 2'b11 && !same_dst:
        gnt = pick0 ? 2'b01 : 2'b10;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q  <= 1'b0;
      age_q <= 1'b0;
    end else begin
      if (&full)
        rr_q <= gnt[REQ_ALU];
      if (&load)
        age_q <= 1'b0;
      else if (load[REQ_ALU] && full[REQ_MEM] && !gnt[REQ_MEM])
        age_q <= 1'b1;
      else if (load[REQ_MEM] && full[REQ_ALU] && !gnt[REQ_ALU])
        age_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signal_reg_write <= 1'b0;
      write_reg        <= '0;
      write_data       <= '0;
    end else begin
      signal_reg_write <= |gnt;
      if (gnt[REQ_ALU]) begin
        write_reg  <= breg[REQ_ALU];
        write_data <= bdata[REQ_ALU];
      end else if (gnt[REQ_MEM]) begin
        write_reg  <= breg[REQ_MEM];
        write_data <= bdata[REQ_MEM];
      end
    end
  end

  // per-register outstanding count: up to both buffers plus the write stage
  assign pending[0] = 1'b0;
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_sb
    logic [1:0] cnt;
    logic       inc_a, inc_b, dec;
    assign inc_a = load[REQ_ALU] && (req_reg_0 == ADDR_W'(r));
    assign inc_b = load[REQ_MEM] && (req_reg_1 == ADDR_W'(r));
    assign dec   = signal_reg_write && (write_reg == ADDR_W'(r));
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        cnt <= 2'd0;
      else
        cnt <= cnt + 2'(inc_a) + 2'(inc_b) - 2'(dec);
    end
    assign pending[r] = |cnt;
  end

  assign hit[0] = (read_reg_1 != '0) && pending[read_reg_1];
  assign hit[1] = (read_reg_2 != '0) && pending[read_reg_2];

`ifdef REGFILE_WRITE_BYPASS_EN
  logic [ADDR_W-1:0] src [2];
  logic [1:0]        fv;
  logic [DATA_W-1:0] fd [2];

  assign src[0] = read_reg_1;
  assign src[1] = read_reg_2;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      logic m0, m1, mw;
      m0    = full[REQ_ALU] && (breg[REQ_ALU] == src[s]);
      m1    = full[REQ_MEM] && (breg[REQ_MEM] == src[s]);
      mw    = signal_reg_write && (write_reg == src[s]);
      fv[s] = 1'b0;
      fd[s] = '0;
      if (src[s] != '0) begin
        if (m0 && m1) begin
          fv[s] = 1'b1;
          fd[s] = age_q ? bdata[REQ_ALU] : bdata[REQ_MEM];
        end else if (m0) begin
          fv[s] = 1'b1;
          fd[s] = bdata[REQ_ALU];
        end else if (m1) begin
          fv[s] = 1'b1;
          fd[s] = bdata[REQ_MEM];
        end else if (mw) begin
          fv[s] = 1'b1;
          fd[s] = write_data;
        end
      end
    end
  end

  assign fwd_valid_1 = fv[0];
  assign fwd_data_1  = fd[0];
  assign fwd_valid_2 = fv[1];
  assign fwd_data_2  = fd[1];
  assign read_stall  = (hit[0] && !fv[0]) || (hit[1] && !fv[1]);
`else
  assign read_stall  = hit[0] || hit[1];
`endif

endmodule
